// File: rtl/fifo_pkg.sv
// Shared types and constants for the async byte FIFO read-side blocks.
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;
endpackage

// File: rtl/fifo_idle_timer.sv
// Saturating idle counter; expired is high while the count sits at MAX.
module fifo_idle_timer
  import fifo_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                         count <= '0;
    else if (clr)                        count <= '0;
    else if (en && (count != W'(MAX)))   count <= count + 1'b1;
  end

  assign expired = (count == W'(MAX));
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a FWFT FIFO and packs PACK_BYTES of them little-endian into a
// valid/ready word. Define FIFO_RD_PACKER_TIMEOUT_EN to flush partial words on idle.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int PACK_BYTES = 4,
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                         rclk,
  input  logic                         rrst_n,
  input  logic                         rempty,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         rinc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*PACK_BYTES-1:0] out_data,
  output logic [PACK_BYTES-1:0]        out_keep
);
  localparam int CNT_W = $clog2(PACK_BYTES + 1);

  packer_state_t state, state_nxt;
  logic [CNT_W-1:0]                     cnt;
  logic [PACK_BYTES-1:0][DATA_W-1:0]    lane_q;
  logic [PACK_BYTES-1:0]                keep_q;
  logic accept, fill_pop, hold_pop, full_pop, expired;

  assign out_valid = (state == HOLD);
  assign accept    = out_valid && out_ready;
  // Popping during accept overlaps the next word's first byte with the handoff.
  assign rinc      = rrst_n && !rempty && ((state == FILL) || accept);
  assign fill_pop  = rinc && (state == FILL);
  assign hold_pop  = rinc && (state == HOLD);
  assign full_pop  = fill_pop && (cnt == CNT_W'(PACK_BYTES - 1));

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  fifo_idle_timer #(.MAX(TIMEOUT)) u_idle (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .clr     (rinc || (state == HOLD) || (state_nxt == HOLD)),
    .en      ((state == FILL) && (cnt != '0) && rempty),
    .expired (expired)
  );
`else
  // Never true for a legal TIMEOUT; a partial word simply waits for more bytes.
  assign expired = (TIMEOUT < 0);
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (full_pop || expired) state_nxt = HOLD;
      HOLD:    if (accept)              state_nxt = FILL;
      default:                          state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)       cnt <= '0;
    else if (fill_pop) cnt <= cnt + 1'b1;
    else if (accept)   cnt <= hold_pop ? CNT_W'(1) : '0;
  end

  for (genvar i = 0; i < PACK_BYTES; i++) begin : g_lane
    logic load;
    assign load = (fill_pop && (cnt == CNT_W'(i))) || ((i == 0) && hold_pop);

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        lane_q[i] <= '0;
        keep_q[i] <= 1'b0;
      end else if (load) begin
        lane_q[i] <= rdata;
        keep_q[i] <= 1'b1;
      end else if (accept) begin
        lane_q[i] <= '0;
        keep_q[i] <= 1'b0;
      end
    end
  end

  assign out_data = lane_q;
  assign out_keep = keep_q;
endmodule
